// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment display driver.
//
// Scans DIGITS digits, advancing one digit per rising edge of scan_clk. scan_clk
// is the divided clock and is synchronous to clk. The displayed hex word
// changes only at a frame boundary, so a frame never mixes two words.
//
// Ports:
//   clk         system clock, the same clock that drives the divider
//   rst_n       asynchronous active-low reset
//   scan_clk    divided clock; each rising edge is one scan tick
//   en          display enable; when low the outputs are dark and ticks are ignored
//   data        hex word; digit k shows data[4k+3:4k]
//   data_valid  a word is offered
//   data_ready  the pending slot is empty; a word is accepted on valid && ready
//   blank_mask  bit k=1 keeps digit k dark
//   dp          bit k=1 lights the decimal point of digit k; sampled live
//   an          digit anodes, SEG_ON level when the digit is selected
//   seg         segments {g,f,e,d,c,b,a}, SEG_ON level when lit
//   dp_n        decimal point, SEG_ON level when lit
//   frame_done  high for the single clk in which a frame transfer happens
module seg_scan #(
  parameter int unsigned DIGITS = 8,
  parameter bit          SEG_ON = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_clk,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LastDigit = CW'(DIGITS - 1);

  typedef enum logic {StIdle, StScan} state_e;

  // Hex decode. Patterns are stored active-low ({g,f,e,d,c,b,a}, 0 = lit).
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    pat = 7'h7F;
    unique case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   digit_q, digit_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic [DW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic            scan_d_q;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_n_q, dp_n_d;

  logic tick;
  logic step;
  logic transfer;
  logic accept;

  // Rising edge of the divided clock. scan_d_q resets low, so a scan_clk that is
  // already high when reset releases counts as a tick in the first cycle.
  assign tick     = scan_clk & ~scan_d_q;
  assign step     = tick & en;
  assign transfer = step & ((state_q == StIdle) | (digit_q == LastDigit));
  assign accept   = data_valid & ~pend_full_q;

  // Marks the transfer clk itself; held low while reset is asserted.
  assign frame_done = transfer & rst_n;
  assign data_ready = ~pend_full_q;

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

  // Scan state, digit counter and the shadow/display registers.
  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    if (step) begin
      unique case (state_q)
        StIdle: begin
          state_d = StScan;
          digit_d = '0;
        end
        StScan: begin
          digit_d = (digit_q == LastDigit) ? '0 : digit_q + CW'(1);
        end
        default: state_d = StIdle;
      endcase
    end

    if (transfer && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end

    // Never collides with the transfer above: an accept needs the slot empty.
    if (accept) begin
      pend_d      = data;
      pend_full_d = 1'b1;
    end
  end

  // Output drive, computed from the next digit so the anodes move one clk
  // after the tick. Only one anode bit can ever be set.
  always_comb begin
    logic [DIGITS-1:0] an_lit;
    logic [6:0]        seg_lit;
    logic              dp_lit;

    an_lit  = '0;
    seg_lit = '0;
    dp_lit  = 1'b0;

    if ((state_d == StScan) && en && !blank_mask[digit_d]) begin
      an_lit[digit_d] = 1'b1;
      seg_lit         = ~seg_decode(disp_d[{digit_d, 2'b00} +: 4]);
      dp_lit          = dp[digit_d];
    end

    an_d   = SEG_ON ? an_lit  : ~an_lit;
    seg_d  = SEG_ON ? seg_lit : ~seg_lit;
    dp_n_d = SEG_ON ? dp_lit  : ~dp_lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      digit_q     <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      scan_d_q    <= 1'b0;
      an_q        <= {DIGITS{~SEG_ON}};
      seg_q       <= {7{~SEG_ON}};
      dp_n_q      <= ~SEG_ON;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      scan_d_q    <= scan_clk;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (DIGITS=8, SEG_ON=0).
// A small reference model predicts each scan step; predicted outputs are queued
// when a tick is driven and popped when the DUT has registered the new digit.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic        en;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  blank_mask;
  logic [7:0]  dp;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  seg_scan #(
    .DIGITS(8),
    .SEG_ON(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_clk  (scan_clk),
    .en        (en),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .blank_mask(blank_mask),
    .dp        (dp),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Decode vectors: {nibble, expected active-low segments}.
  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;
  dec_vec_t vecs [16];

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;
  } exp_t;
  exp_t sb [$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int          m_state;  // 0 = idle, 1 = scanning
  int          m_digit;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  bit          m_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] n);
    for (int i = 0; i < 16; i++) if (vecs[i].nib == n) return vecs[i].seg;
    return 7'h7F;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_digit = 0;
    m_disp  = '0;
    m_pend  = '0;
    m_full  = 1'b0;
    sb.delete();
  endtask

  task automatic push_expected();
    exp_t e;
    e.an   = 8'hFF;
    e.seg  = 7'h7F;
    e.dp_n = 1'b1;
    if (m_state == 1 && en && !blank_mask[m_digit]) begin
      e.an   = ~(8'h01 << m_digit);
      e.seg  = dec(m_disp[4*m_digit +: 4]);
      e.dp_n = ~dp[m_digit];
    end
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_an"},   an,   e.an);
      chk({tag, "_seg"},  seg,  e.seg);
      chk({tag, "_dp_n"}, dp_n, e.dp_n);
    end
  endtask

  // One scan_clk pulse: high for one clk, then low for one clk.
  task automatic tick();
    bit fd;
    scan_clk = 1'b1;
    #1;
    fd = 1'b0;
    if (en) begin
      fd = (m_state == 0) || (m_digit == 7);
      if (m_state == 0) begin
        m_state = 1;
        m_digit = 0;
      end else begin
        m_digit = (m_digit + 1) % 8;
      end
      if (fd && m_full) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end
    end
    chk("frame_done_tick", frame_done, fd);
    push_expected();
    @(posedge clk); #1;
    scan_clk = 1'b0;
    check_out("tick");
    @(posedge clk); #1;
    chk("frame_done_idle", frame_done, 1'b0);
    chk("data_ready", data_ready, !m_full);
  endtask

  task automatic offer(input logic [31:0] w);
    chk("ready_pre_offer", data_ready, !m_full);
    data       = w;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    if (!m_full) begin
      m_pend = w;
      m_full = 1'b1;
    end
    chk("ready_post_offer", data_ready, !m_full);
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"},    an,         8'hFF);
    chk({tag, "_seg"},   seg,        7'h7F);
    chk({tag, "_dp_n"},  dp_n,       1'b1);
    chk({tag, "_fd"},    frame_done, 1'b0);
    chk({tag, "_ready"}, data_ready, 1'b1);
  endtask

  initial begin
    vecs = '{
      '{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
      '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
      '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
      '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}
    };

    rst_n      = 1'b0;
    scan_clk   = 1'b0;
    en         = 1'b1;
    data       = '0;
    data_valid = 1'b0;
    blank_mask = '0;
    dp         = '0;
    model_reset();

    // Reset state, then idle with scan_clk held low.
    repeat (3) @(posedge clk);
    #1;
    check_dark("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_dark("idle");
    end

    // First tick: IDLE entry is a frame boundary, digit 0 shows 0.
    tick();

    // Accept a word; it appears only after the wrap.
    offer(32'h89ABCDEF);
    for (int i = 0; i < 15; i++) tick();  // digits 1..7, wrap, digits 1..7

    // New word offered mid-frame: old values until the wrap.
    tick();
    tick();                               // digit 1
    offer(32'h11111111);
    for (int i = 0; i < 14; i++) tick();  // digits 2..7, 0..7

    // Table-driven decode sweep over all sixteen nibbles.
    offer(32'h76543210);
    for (int i = 0; i < 8; i++) tick();
    offer(32'hFEDCBA98);
    for (int i = 0; i < 8; i++) tick();

    // Blanking and decimal points.
    blank_mask = 8'h0C;
    dp         = 8'h01;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) tick();
    blank_mask = 8'h00;
    dp         = 8'h00;
    @(posedge clk); #1;

    // Enable dropped at digit 5; ticks ignored, handshake still live.
    for (int i = 0; i < 6; i++) tick();   // digits 0..5
    en = 1'b0;
    @(posedge clk); #1;
    push_expected();
    check_out("en_off");
    tick();
    tick();
    offer(32'h12345678);
    en = 1'b1;
    tick();                               // digit 6, still the old word

    // Reset mid-operation with the pending slot full.
    for (int i = 0; i < 6; i++) tick();   // 7, wrap 0, 1..4
    offer(32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    check_dark("mid_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_dark("post_reset");
    for (int i = 0; i < 9; i++) tick();   // shows zeros, discarded word never appears

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
